fibo_seq_scheduler: RTL



---
 rtl/fibo_seq_scheduler.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fibo_seq_scheduler.sv
// ----------------------------------------------------------------------------
// fibo_seq_scheduler
//
// Playlist controller for the sequence-generator datapath. A small table of
// {sequence select, term count} entries is walked in order. For every entry
// with a non-zero count the generator select is driven, a one-cycle sequence
// reset is issued, and exactly `count` terms are requested over a req/ack
// handshake. Entries with a zero count are skipped without touching the
// generator.
//
// Build option:
//   FIBO_SCHED_LOOP_EN - when defined, the playlist restarts at entry 0 after
//                        the last entry (pulsing wrap_o) for as long as at
//                        least one entry ran in the pass. The loop only ends
//                        on abort. When undefined, one pass is made, then
//                        done_o pulses, and wrap_o is tied low.
//
// Ports:
//   clk           clock
//   rst_n         asynchronous active-low reset (clears table and outputs)
//   ena_i         clock enable; low freezes every register
//   cfg_we_i      table write strobe (honoured only while idle)
//   cfg_addr_i    table entry index
//   cfg_data_i    {sel[1:0], count[CNT_W-1:0]}
//   start_i       begin a playlist pass (sampled while idle)
//   abort_i       return to idle immediately (ignored while idle)
//   step_ack_i    generator produced one term
//   gen_value_i   generator's current value, valid with step_ack_i
//   seq_sel_o     sequence select to the generator
//   seq_rst_o     one-cycle sequence-reset pulse
//   step_req_o    term request, held until acknowledged
//   busy_o        high whenever not idle
//   cur_entry_o   table entry being processed
//   term_cnt_o    terms acknowledged in the current entry
//   last_value_o  gen_value_i captured at the most recent ack
//   done_o        one-cycle pulse on normal return to idle
//   wrap_o        one-cycle pulse when the playlist wraps (loop build only)
// ----------------------------------------------------------------------------
module fibo_seq_scheduler #(
    parameter int  ENTRIES = 4,
    parameter int  CNT_W   = 6,
    localparam int AW      = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena_i,
    input  logic             cfg_we_i,
    input  logic [AW-1:0]    cfg_addr_i,
    input  logic [CNT_W+1:0] cfg_data_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             step_ack_i,
    input  logic [15:0]      gen_value_i,
    output logic [1:0]       seq_sel_o,
    output logic             seq_rst_o,
    output logic             step_req_o,
    output logic             busy_o,
    output logic [AW-1:0]    cur_entry_o,
    output logic [CNT_W-1:0] term_cnt_o,
    output logic [15:0]      last_value_o,
    output logic             done_o,
    output logic             wrap_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RESET,
        S_RUN,
        S_NEXT
    } state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    cur_entry_q, cur_entry_d;
    logic             ran_q, ran_d;
    logic [1:0]       seq_sel_q, seq_sel_d;
    logic [CNT_W-1:0] term_cnt_q, term_cnt_d;
    logic [15:0]      last_value_q, last_value_d;
    logic             done_q, done_d;
`ifdef FIBO_SCHED_LOOP_EN
    logic             wrap_q, wrap_d;
`endif

    // Playlist table, split into select and count fields.
    logic [1:0]       tbl_sel_q [ENTRIES];
    logic [CNT_W-1:0] tbl_cnt_q [ENTRIES];

    logic             tbl_we;
    logic [1:0]       ent_sel;
    logic [CNT_W-1:0] ent_cnt;
    logic [CNT_W-1:0] term_inc;
    logic             last_entry;

    // The table is read at the current entry for the whole time that entry
    // is active; it cannot change meanwhile because writes are blocked
    // while busy, so no separate count latch is needed.
    assign ent_sel    = tbl_sel_q[cur_entry_q];
    assign ent_cnt    = tbl_cnt_q[cur_entry_q];
    assign term_inc   = term_cnt_q + CNT_W'(1);
    assign last_entry = (cur_entry_q == AW'(ENTRIES - 1));
    assign tbl_we     = ena_i && cfg_we_i && (state_q == S_IDLE);

    // Table storage: cleared asynchronously by reset, written only while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_sel_q[i] <= '0;
                tbl_cnt_q[i] <= '0;
            end
        end else if (tbl_we) begin
            tbl_sel_q[cfg_addr_i] <= cfg_data_i[CNT_W+1:CNT_W];
            tbl_cnt_q[cfg_addr_i] <= cfg_data_i[CNT_W-1:0];
        end
    end

    // State and datapath registers; everything holds while ena_i is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cur_entry_q  <= '0;
            ran_q        <= 1'b0;
            seq_sel_q    <= '0;
            term_cnt_q   <= '0;
            last_value_q <= '0;
            done_q       <= 1'b0;
`ifdef FIBO_SCHED_LOOP_EN
            wrap_q       <= 1'b0;
`endif
        end else if (ena_i) begin
            state_q      <= state_d;
            cur_entry_q  <= cur_entry_d;
            ran_q        <= ran_d;
            seq_sel_q    <= seq_sel_d;
            term_cnt_q   <= term_cnt_d;
            last_value_q <= last_value_d;
            done_q       <= done_d;
`ifdef FIBO_SCHED_LOOP_EN
            wrap_q       <= wrap_d;
`endif
        end
    end

    // Next-state logic. Abort outranks everything outside IDLE and leaves
    // the captured datapath values (term count, last value, select) alone.
    // done/wrap are registered pulses so they line up with the first cycle
    // of the state they announce.
    always_comb begin
        state_d      = state_q;
        cur_entry_d  = cur_entry_q;
        ran_d        = ran_q;
        seq_sel_d    = seq_sel_q;
        term_cnt_d   = term_cnt_q;
        last_value_d = last_value_q;
        done_d       = 1'b0;
`ifdef FIBO_SCHED_LOOP_EN
        wrap_d       = 1'b0;
`endif

        if ((state_q != S_IDLE) && abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_d     = S_LOAD;
                        cur_entry_d = '0;
                        ran_d       = 1'b0;
                    end
                end

                S_LOAD: begin
                    if (ent_cnt == '0) begin
                        state_d = S_NEXT;
                    end else begin
                        state_d   = S_RESET;
                        seq_sel_d = ent_sel;
                        ran_d     = 1'b1;
                    end
                end

                S_RESET: begin
                    term_cnt_d = '0;
                    state_d    = S_RUN;
                end

                // The exit compare uses the incremented count, so term_cnt
                // can never run past the entry's count and never wraps.
                S_RUN: begin
                    if (step_ack_i) begin
                        last_value_d = gen_value_i;
                        term_cnt_d   = term_inc;
                        if (term_inc == ent_cnt) begin
                            state_d = S_NEXT;
                        end
                    end
                end

                S_NEXT: begin
                    if (!last_entry) begin
                        cur_entry_d = cur_entry_q + AW'(1);
                        state_d     = S_LOAD;
                    end else begin
`ifdef FIBO_SCHED_LOOP_EN
                        // An all-zero table would otherwise spin forever
                        // without ever touching the generator.
                        if (ran_q) begin
                            wrap_d      = 1'b1;
                            cur_entry_d = '0;
                            ran_d       = 1'b0;
                            state_d     = S_LOAD;
                        end else begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
`else
                        done_d  = 1'b1;
                        state_d = S_IDLE;
`endif
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Outputs come straight from registers so no input reaches an output
    // combinationally.
    always_comb begin
        busy_o       = (state_q != S_IDLE);
        seq_rst_o    = (state_q == S_RESET);
        step_req_o   = (state_q == S_RUN);
        seq_sel_o    = seq_sel_q;
        cur_entry_o  = cur_entry_q;
        term_cnt_o   = term_cnt_q;
        last_value_o = last_value_q;
        done_o       = done_q;
`ifdef FIBO_SCHED_LOOP_EN
        wrap_o       = wrap_q;
`else
        wrap_o       = 1'b0;
`endif
    end

endmodule
